// File: rtl/miss_fill_engine.sv
// Miss fill engine: accepts one registered miss, picks a victim way, bursts the
// block in from memory into the data array, forwards the missed word to the core
// and finally commits the tag and status arrays.
module miss_fill_engine #(
    parameter int unsigned TAG_W    = 8,
    parameter int unsigned SET_W    = 4,
    parameter int unsigned OFF_W    = 4,
    parameter int unsigned WORD_W   = 20,
    parameter int unsigned NUM_WAYS = 4,
    parameter int unsigned CWF      = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    // miss request from the compare stage
    input  logic                         i_miss_valid,
    output logic                         o_miss_ready,
    input  logic [TAG_W-1:0]             i_miss_tag,
    input  logic [SET_W-1:0]             i_miss_set,
    input  logic [OFF_W-1:0]             i_miss_offset,
    input  logic [NUM_WAYS-1:0]          i_status_valid,
    // memory interface
    output logic [TAG_W+SET_W+OFF_W-1:0] o_mem_req_addr,
    output logic                         o_mem_req_valid,
    input  logic                         i_mem_req_ready,
    input  logic [WORD_W-1:0]            i_mem_data,
    input  logic                         i_mem_data_valid,
    output logic                         o_mem_data_ready,
    // data array write port
    output logic [SET_W+OFF_W-1:0]       o_da_addr,
    output logic [WORD_W-1:0]            o_da_data,
    output logic [NUM_WAYS-1:0]          o_da_way_mask,
    output logic                         o_da_valid,
    input  logic                         i_da_halt,
    // tag array write port
    output logic [SET_W-1:0]             o_ta_addr,
    output logic [TAG_W-1:0]             o_ta_data,
    output logic [NUM_WAYS-1:0]          o_ta_way_mask,
    output logic                         o_ta_valid,
    input  logic                         i_ta_halt,
    // status array write port
    output logic [SET_W-1:0]             o_sa_addr,
    output logic [NUM_WAYS-1:0]          o_sa_way_mask,
    output logic                         o_sa_valid,
    input  logic                         i_sa_halt,
    // core forwarding and status
    output logic [WORD_W-1:0]            o_word,
    output logic                         o_word_valid,
    output logic                         o_miss_state,
    output logic                         o_done
);

    localparam int unsigned WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StFill,
        StUpdate,
        StDone
    } state_e;

    state_e state_q, state_d;

    logic [TAG_W-1:0]    tag_q;
    logic [SET_W-1:0]    set_q;
    logic [OFF_W-1:0]    off_q;
    logic [WAY_W-1:0]    victim_q;
    logic [WAY_W-1:0]    rr_q;
    logic [OFF_W-1:0]    beat_q;
    logic [WORD_W-1:0]   word_q;
    logic                word_valid_q;

    logic                free_found;
    logic [WAY_W-1:0]    free_idx;
    logic                accept_miss;
    logic                beat_fire;
    logic                last_beat;
    logic [OFF_W-1:0]    start_off;
    logic [OFF_W-1:0]    beat_off;
    logic [NUM_WAYS-1:0] victim_mask;

    // Lowest-index invalid way in the missed set, if any.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (!i_status_valid[i]) begin
                free_found = 1'b1;
                free_idx   = WAY_W'(i);
            end
        end
    end

    assign accept_miss = (state_q == StIdle) && i_miss_valid && !rst;
    assign beat_fire   = (state_q == StFill) && i_mem_data_valid && !i_da_halt && !rst;
    assign last_beat   = (beat_q == {OFF_W{1'b1}});
    assign start_off   = (CWF != 0) ? off_q : {OFF_W{1'b0}};
    // Offset arithmetic wraps in OFF_W bits, giving the critical-word-first rotation.
    assign beat_off    = start_off + beat_q;
    assign victim_mask = NUM_WAYS'(1) << victim_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Miss capture, victim selection, beat counting and word forwarding.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_q        <= '0;
            set_q        <= '0;
            off_q        <= '0;
            victim_q     <= '0;
            rr_q         <= '0;
            beat_q       <= '0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
        end else begin
            if (accept_miss) begin
                tag_q    <= i_miss_tag;
                set_q    <= i_miss_set;
                off_q    <= i_miss_offset;
                victim_q <= free_found ? free_idx : rr_q;
                // Pointer only advances when a valid way is actually evicted.
                if (!free_found) begin
                    rr_q <= rr_q + WAY_W'(1);
                end
            end
            if ((state_q == StReq) && i_mem_req_ready) begin
                beat_q <= '0;
            end else if (beat_fire) begin
                beat_q <= beat_q + OFF_W'(1);
            end
            word_valid_q <= beat_fire && (beat_off == off_q);
            if (beat_fire && (beat_off == off_q)) begin
                word_q <= i_mem_data;
            end
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d          = state_q;
        o_miss_ready     = 1'b0;
        o_mem_req_valid  = 1'b0;
        o_mem_data_ready = 1'b0;
        o_da_valid       = 1'b0;
        o_ta_valid       = 1'b0;
        o_sa_valid       = 1'b0;
        o_done           = 1'b0;
        unique case (state_q)
            StIdle: begin
                o_miss_ready = 1'b1;
                if (i_miss_valid) begin
                    state_d = StReq;
                end
            end
            StReq: begin
                o_mem_req_valid = 1'b1;
                if (i_mem_req_ready) begin
                    state_d = StFill;
                end
            end
            StFill: begin
                o_mem_data_ready = !i_da_halt;
                o_da_valid       = i_mem_data_valid;
                if (beat_fire && last_beat) begin
                    state_d = StUpdate;
                end
            end
            StUpdate: begin
                o_ta_valid = 1'b1;
                o_sa_valid = 1'b1;
                // Tag and status commit together or not at all.
                if (!i_ta_halt && !i_sa_halt) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                o_done  = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        // Reset aborts any fill in flight and silences every request.
        if (rst) begin
            state_d          = StIdle;
            o_miss_ready     = 1'b0;
            o_mem_req_valid  = 1'b0;
            o_mem_data_ready = 1'b0;
            o_da_valid       = 1'b0;
            o_ta_valid       = 1'b0;
            o_sa_valid       = 1'b0;
            o_done           = 1'b0;
        end
    end

    assign o_mem_req_addr = {tag_q, set_q, start_off};
    assign o_da_addr      = {set_q, beat_off};
    assign o_da_data      = i_mem_data;
    assign o_da_way_mask  = victim_mask;
    assign o_ta_addr      = set_q;
    assign o_ta_data      = tag_q;
    assign o_ta_way_mask  = victim_mask;
    assign o_sa_addr      = set_q;
    assign o_sa_way_mask  = victim_mask;
    assign o_word         = word_q;
    assign o_word_valid   = word_valid_q && !rst;
    assign o_miss_state   = (state_q != StIdle);

endmodule
